// File: rtl/rdyack_fifo_pkg.sv
// rtl/rdyack_fifo_pkg.sv - shared helpers for rdy/ack buffers
// Occupancy-count width function reused by any buffer that reports a 0..DEPTH fill level.
package rdyack_fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rdyack_fifo_ptr.sv
// rtl/rdyack_fifo_ptr.sv - modulo-DEPTH wrap counter for FIFO read/write pointers
// Wraps explicitly at DEPTH-1, so DEPTH need not be a power of two.
module rdyack_fifo_ptr #(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_inc,
  output logic [PW-1:0] o_ptr
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ptr <= '0;
    end else if (i_inc) begin
      o_ptr <= (o_ptr == PW'(DEPTH - 1)) ? '0 : o_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rdyack_fifo.sv
// rtl/rdyack_fifo.sv - rdy/ack FIFO between two handshake stages
// Optional zero-latency pass-through when empty: define RDYACK_FIFO_BYPASS_EN.
module rdyack_fifo
  import rdyack_fifo_pkg::*;
#(
  parameter int BW    = 32,
  parameter int DEPTH = 4,
  localparam int CW   = cnt_width(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          src_rdy,
  output logic          src_ack,
  input  logic [BW-1:0] i_data,
  output logic          dst_rdy,
  input  logic          dst_ack,
  output logic [BW-1:0] o_data,
  output logic [CW-1:0] o_n
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] n;
  logic [BW-1:0] mem [DEPTH];
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (n == CW'(DEPTH));
  assign empty = (n == '0);
  assign o_n   = n;

`ifdef RDYACK_FIFO_BYPASS_EN
  logic byp;

  // When empty, the offered word is presented directly; it is stored only if not taken.
  always_comb begin
    byp     = empty && src_rdy && !i_rst;
    src_ack = src_rdy && !full && !i_rst;
    dst_rdy = (!empty || src_rdy) && !i_rst;
    o_data  = byp ? i_data : mem[rp];
    push    = src_ack && !(byp && dst_ack);
    pop     = dst_rdy && dst_ack && !byp;
  end
`else
  // src_ack ignores dst_ack, so a full FIFO cannot accept in the cycle it pops.
  always_comb begin
    src_ack = src_rdy && !full && !i_rst;
    dst_rdy = !empty && !i_rst;
    o_data  = mem[rp];
    push    = src_rdy && src_ack;
    pop     = dst_rdy && dst_ack;
  end
`endif

  rdyack_fifo_ptr #(.DEPTH(DEPTH)) u_wp (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (push),
    .o_ptr (wp)
  );

  rdyack_fifo_ptr #(.DEPTH(DEPTH)) u_rp (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (pop),
    .o_ptr (rp)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      n <= '0;
    end else if (push && !pop) begin
      n <= n + 1'b1;
    end else if (pop && !push) begin
      n <= n - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wp] <= i_data;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow:  assert property (@(posedge i_clk) disable iff (i_rst) n <= CW'(DEPTH));
  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst) !(empty && pop));
  a_ack_ignored:  assert property (@(posedge i_clk) disable iff (i_rst) (dst_ack && !dst_rdy) |-> !pop);
`endif

endmodule

// File: tb/tb_rdyack_fifo.sv
// tb/tb_rdyack_fifo.sv - directed and scoreboarded checks for rdyack_fifo
// Expectations adapt to the RDYACK_FIFO_BYPASS_EN build.
module tb_rdyack_fifo;

`ifdef RDYACK_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, src_rdy, src_ack, dst_rdy, dst_ack;
  logic [31:0] data, o_data;
  logic [2:0]  o_n;

  logic        rst_b, src_rdy_b, src_ack_b, dst_rdy_b, dst_ack_b;
  logic [31:0] data_b, o_data_b;
  logic [1:0]  o_n_b;

  rdyack_fifo #(.BW(32), .DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .src_rdy(src_rdy), .src_ack(src_ack), .i_data(data),
    .dst_rdy(dst_rdy), .dst_ack(dst_ack), .o_data(o_data), .o_n(o_n)
  );

  rdyack_fifo #(.BW(32), .DEPTH(3)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .src_rdy(src_rdy_b), .src_ack(src_ack_b), .i_data(data_b),
    .dst_rdy(dst_rdy_b), .dst_ack(dst_ack_b), .o_data(o_data_b), .o_n(o_n_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          srdy;
    logic [31:0] d;
    bit          ack;
    bit          e_sack;
    bit          e_drdy;
    bit          chk_o;
    logic [31:0] e_o;
    bit          chk_n;
    logic [2:0]  e_n;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, logic [31:0] d, bit a, bit es, bit ed,
                              bit co, logic [31:0] eo, bit cn, logic [2:0] en);
    vec_t v;
    v.rst = r; v.srdy = s; v.d = d; v.ack = a; v.e_sack = es; v.e_drdy = ed;
    v.chk_o = co; v.e_o = eo; v.chk_n = cn; v.e_n = en;
    return v;
  endfunction

  vec_t vecs [18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, cyc, popped, wd;
    int q[$];
    bit exp_s, exp_d, do_pop;
    logic [31:0] exp_o;

    rst = 1; src_rdy = 0; dst_ack = 0; data = 0;
    rst_b = 1; src_rdy_b = 0; dst_ack_b = 0; data_b = 0;

    // reset, fill to full, full-with-pop, drain, reset mid-transfer
    vecs[0]  = mk(1, 1, 32'hA0, 1, 0, 0,   0,   0,      0, 0);
    vecs[1]  = mk(1, 1, 32'hA0, 1, 0, 0,   0,   0,      1, 0);
    vecs[2]  = mk(0, 1, 32'hA0, 0, 1, BYP, BYP, 32'hA0, 1, 0);
    vecs[3]  = mk(0, 1, 32'hA1, 0, 1, 1,   1,   32'hA0, 1, 1);
    vecs[4]  = mk(0, 1, 32'hA2, 0, 1, 1,   1,   32'hA0, 1, 2);
    vecs[5]  = mk(0, 1, 32'hA3, 0, 1, 1,   1,   32'hA0, 1, 3);
    vecs[6]  = mk(0, 1, 32'hA4, 0, 0, 1,   1,   32'hA0, 1, 4);
    vecs[7]  = mk(0, 1, 32'hA4, 1, 0, 1,   1,   32'hA0, 1, 4);
    vecs[8]  = mk(0, 1, 32'hA4, 0, 1, 1,   1,   32'hA1, 1, 3);
    vecs[9]  = mk(0, 0, 32'h0,  1, 0, 1,   1,   32'hA1, 1, 4);
    vecs[10] = mk(0, 0, 32'h0,  1, 0, 1,   1,   32'hA2, 1, 3);
    vecs[11] = mk(0, 0, 32'h0,  1, 0, 1,   1,   32'hA3, 1, 2);
    vecs[12] = mk(0, 0, 32'h0,  1, 0, 1,   1,   32'hA4, 1, 1);
    vecs[13] = mk(0, 0, 32'h0,  1, 0, 0,   0,   0,      1, 0);
    vecs[14] = mk(0, 1, 32'hB0, 0, 1, BYP, BYP, 32'hB0, 1, 0);
    vecs[15] = mk(0, 1, 32'hB1, 0, 1, 1,   1,   32'hB0, 1, 1);
    vecs[16] = mk(1, 1, 32'hB1, 1, 0, 0,   0,   0,      1, 2);
    vecs[17] = mk(0, 0, 32'h0,  1, 0, 0,   0,   0,      1, 0);

    for (int i = 0; i < 18; i++) begin
      rst = vecs[i].rst; src_rdy = vecs[i].srdy; data = vecs[i].d; dst_ack = vecs[i].ack;
      #1;
      chk($sformatf("vec%0d_src_ack", i), {31'b0, src_ack}, {31'b0, vecs[i].e_sack});
      chk($sformatf("vec%0d_dst_rdy", i), {31'b0, dst_rdy}, {31'b0, vecs[i].e_drdy});
      if (vecs[i].chk_o) chk($sformatf("vec%0d_o_data", i), o_data, vecs[i].e_o);
      if (vecs[i].chk_n) chk($sformatf("vec%0d_o_n", i), {29'b0, o_n}, {29'b0, vecs[i].e_n});
      @(posedge clk); #1;
    end

    // streaming: one word per cycle after the first-word latency
    src_rdy = 1; dst_ack = 1; sent = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 200) begin
      data = sent;
      #1;
      chk("stream_src_ack", {31'b0, src_ack}, 32'd1);
      if (cyc == 0 && !BYP) begin
        chk("stream_first_latency", {31'b0, dst_rdy}, 32'd0);
      end else begin
        chk("stream_dst_rdy", {31'b0, dst_rdy}, 32'd1);
        chk("stream_data", o_data, got);
      end
      chk("stream_n", {29'b0, o_n}, (cyc == 0 || BYP) ? 32'd0 : 32'd1);
      if (dst_rdy && dst_ack) got++;
      if (src_ack) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_done", got, 32'd100);
    src_rdy = 0;
    #1;
    chk("stream_tail_rdy", {31'b0, dst_rdy}, {31'b0, !BYP});
    if (dst_rdy) chk("stream_tail_data", o_data, 32'd100);
    @(posedge clk); #1;
    chk("stream_drained_n", {29'b0, o_n}, 32'd0);

    // empty FIFO offered a word that is taken in the same cycle
    dst_ack = 1; src_rdy = 1; data = 32'h55;
    #1;
    chk("byp_src_ack", {31'b0, src_ack}, 32'd1);
    chk("byp_dst_rdy", {31'b0, dst_rdy}, {31'b0, BYP});
    if (dst_rdy) chk("byp_o_data", o_data, 32'h55);
    @(posedge clk); #1;
    src_rdy = 0; data = 0;
    #1;
    chk("byp_n_after", {29'b0, o_n}, BYP ? 32'd0 : 32'd1);
    chk("byp_next_rdy", {31'b0, dst_rdy}, {31'b0, !BYP});
    if (dst_rdy) chk("byp_next_data", o_data, 32'h55);
    @(posedge clk); #1;
    chk("byp_final_n", {29'b0, o_n}, 32'd0);
    dst_ack = 0;

    // DEPTH=3, random handshakes against a queue model
    rst_b = 1;
    @(posedge clk); #1;
    rst_b = 0;
    popped = 0; cyc = 0; wd = 32'h1000;
    while (popped < 500 && cyc < 5000) begin
      if (!src_rdy_b) src_rdy_b = 1'($urandom_range(0, 1));
      data_b = wd;
      dst_ack_b = 1'($urandom_range(0, 1));
      #1;
      exp_s = src_rdy_b && (q.size() < 3);
      exp_d = (q.size() > 0) || (BYP && src_rdy_b);
      chk("rnd_src_ack", {31'b0, src_ack_b}, {31'b0, exp_s});
      chk("rnd_dst_rdy", {31'b0, dst_rdy_b}, {31'b0, exp_d});
      chk("rnd_n", {30'b0, o_n_b}, q.size());
      do_pop = exp_d && dst_ack_b;
      if (do_pop) begin
        exp_o = (q.size() > 0) ? q[0] : data_b;
        chk("rnd_data", o_data_b, exp_o);
      end
      if (exp_s) q.push_back(data_b);
      if (do_pop) begin
        void'(q.pop_front());
        popped++;
      end
      @(posedge clk); #1;
      if (exp_s) begin
        wd++;
        src_rdy_b = 0;
      end
      cyc++;
    end
    chk("rnd_done", popped, 32'd500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rdyack_fifo.md
Name: rdyack_fifo

Overview:
- Parameterised rdy/ack FIFO that buffers a data word between two handshake stages.
- Sits directly downstream of the flow-control / loop-controller stages, feeding the next consumer.
- Absorbs stalls so the upstream semaphore-paced stream keeps issuing while the consumer is busy.
- Registered boundaries break the combinational ack chain, except in bypass mode.

Parameters:
- BW, 32, data word width in bits.
- DEPTH, 4, number of storage entries; any integer >= 2, not required to be a power of two.
- CW, $clog2(DEPTH+1), derived local width of the occupancy count; not overridable.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst  input  1  synchronous reset, active-high.
- src_rdy  input  1  upstream offers i_data.
- src_ack  output  1  FIFO accepts i_data this cycle.
- i_data  input  BW  write data; valid while src_rdy.
- dst_rdy  output  1  FIFO offers o_data.
- dst_ack  input  1  downstream accepts o_data this cycle.
- o_data  output  BW  head entry; valid while dst_rdy.
- o_n  output  CW  current occupancy, 0..DEPTH.

Behaviour:
- Handshake rules:
  - A transfer happens on a cycle with rdy && ack.
  - Upstream holds src_rdy and i_data stable until acked.
  - dst_rdy, once raised, stays high and o_data stays stable until dst_ack.
  - dst_ack may depend combinationally on dst_rdy.
- State:
  - Write pointer wp and read pointer rp, each 0..DEPTH-1.
  - Count n, driven out as o_n.
  - Storage array mem[DEPTH][BW]; storage is not reset.
- Reset (i_rst=1 at a rising edge):
  - wp=0, rp=0, n=0.
  - While i_rst is high: src_ack=0, dst_rdy=0; o_data is don't-care.
  - Reset mid-transfer discards all stored entries; no partial state survives.
- Combinational outputs:
  - full = (n==DEPTH); empty = (n==0).
  - src_ack = src_rdy && !full && !i_rst. Does not depend on dst_ack, so there is no pass-through of ack.
  - dst_rdy = !empty && !i_rst.
  - o_data = mem[rp].
- Push (src_rdy && src_ack): mem[wp] <= i_data; wp <= (wp==DEPTH-1) ? 0 : wp+1.
- Pop (dst_rdy && dst_ack): rp <= (rp==DEPTH-1) ? 0 : rp+1.
- Count update:
  - Push only: n+1.
  - Pop only: n-1.
  - Push and pop together: n unchanged, both pointers advance.
  - Neither: all state held.
- Latency: a word pushed at cycle t is visible on dst_rdy/o_data at t+1 at the earliest.
- Full boundary:
  - When n==DEPTH, src_ack=0 even if dst_ack=1 in the same cycle. The freed slot becomes available next cycle.
  - Sustained throughput is 1 word/cycle while 0 < n < DEPTH.
- Empty boundary: when n==0, dst_rdy=0 and no pop occurs.
- Wrap-around: pointers wrap explicitly at DEPTH-1 (no power-of-two masking). Ordering is strictly FIFO across wraps.
- Illegal conditions, flagged by assertions in simulation only:
  - dst_ack without dst_rdy is ignored.
  - n never exceeds DEPTH or underflows.

Optional Feature:
- Macro: RDYACK_FIFO_BYPASS_EN.
- Defined, when empty && src_rdy && !i_rst:
  - dst_rdy=1 and o_data=i_data combinationally.
  - If dst_ack=1: src_ack=1, the word passes through with zero latency, nothing is stored, and n, wp, rp are unchanged.
  - If dst_ack=0: src_ack=1, the word is stored normally (n becomes 1).
  - When n>0, behaviour is identical to the non-bypass build.
- Undefined:
  - Behaviour exactly as described above; minimum latency is 1 cycle.
  - There is no combinational path from src to dst.

Decomposition:
- Shared package: no new typedefs. The CW width function (clog2 of DEPTH+1) lives beside the existing rdy/ack port macros so other buffers reuse it.
- One natural sub-module, rdyack_fifo_ptr:
  - Modulo-DEPTH wrap counter with inputs i_clk, i_rst, i_inc; output o_ptr.
  - Instantiated twice, for wp and rp.
  - Count logic and storage stay in the top module.

Test Plan:
- Reset: assert i_rst 2 cycles with src_rdy=1 and dst_ack=1 -> src_ack=0, dst_rdy=0 throughout; after release o_n=0.
- Fill/drain, DEPTH=4, dst_ack=0: push 0xA0..0xA3 -> o_n=4, src_ack=0 on 5th offer (0xA4). Then dst_ack=1 -> pops A0,A1,A2,A3 in order; A4 is accepted the cycle after the first pop.
- Streaming: src_rdy=1 and dst_ack=1 continuously, 100 words, incrementing data -> after the first-word latency of 1 cycle, one word per cycle; o_n steady at 1; data in order.
- Wrap with DEPTH=3: random rdy/ack at 50% each, 500 words -> scoreboard in-order match; o_n never >3; pointers wrap at 2.
- Full with simultaneous pop: n=4, src_rdy=1, dst_ack=1 -> that cycle pop only, src_ack=0; next cycle push accepted, o_n=4.
- Bypass (RDYACK_FIFO_BYPASS_EN): empty, src_rdy=1, i_data=0x55, dst_ack=1 -> same cycle dst_rdy=1, o_data=0x55, src_ack=1, o_n stays 0. Without the macro, dst_rdy=1 only next cycle.
